// File: rtl/sap_program_loader.sv
// sap_program_loader: streams a SAP program into the 16x16 instruction RAM
// and arbitrates RAM access with the CPU. Optional: SAP_LOADER_CHECKSUM_EN.
module sap_program_loader #(
   parameter int ADDR_WIDTH = 4,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic [ADDR_WIDTH:0]     i_word_count,
   input  logic                    i_byte_valid,
   input  logic [BYTE_WIDTH-1:0]   i_byte,
   output logic                    o_byte_ready,
   input  logic [ADDR_WIDTH-1:0]   i_cpu_address,
   input  logic [2*BYTE_WIDTH-1:0] i_cpu_data,
   input  logic                    i_cpu_write,
   input  logic                    i_cpu_read,
   output logic [ADDR_WIDTH-1:0]   o_ram_address,
   output logic [2*BYTE_WIDTH-1:0] o_ram_data,
   output logic                    o_ram_write,
   output logic                    o_ram_read,
   output logic                    o_cpu_hold,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_error
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_WIDTH);

`ifdef SAP_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE, S_HI, S_LO, S_WRITE, S_DONE, S_CHK
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_HI, S_LO, S_WRITE, S_DONE
   } state_t;
`endif

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic [BYTE_WIDTH-1:0]   op_q, op_d;
   logic [BYTE_WIDTH-1:0]   opnd_q, opnd_d;
   logic                    busy_q, busy_d;
   logic                    hold_q, hold_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
`ifdef SAP_LOADER_CHECKSUM_EN
   logic [BYTE_WIDTH-1:0]   sum_q, sum_d;
`endif

   logic            accept;
   logic            last_word;
   logic [CW-1:0]   count_sat;

   assign o_byte_ready = (state_q == S_HI) || (state_q == S_LO)
`ifdef SAP_LOADER_CHECKSUM_EN
                      || (state_q == S_CHK)
`endif
                      ;
   assign accept    = i_byte_valid & o_byte_ready;
   assign last_word = ({1'b0, ptr_q} == (count_q - CW'(1)));
   assign count_sat = (i_word_count > DEPTH) ? DEPTH : i_word_count;

   assign o_busy     = busy_q;
   assign o_cpu_hold = hold_q;
   assign o_done     = done_q;
   assign o_error    = error_q;

   // Next-state logic: load sequencing, error tracking and status flags.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      op_d    = op_q;
      opnd_d  = opnd_q;
      error_d = error_q;
`ifdef SAP_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               count_d = count_sat;
               ptr_d   = '0;
               error_d = 1'b0;
`ifdef SAP_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
               state_d = (count_sat == '0) ? S_DONE : S_HI;
            end
         end
         S_HI: begin
            if (accept) begin
               op_d    = i_byte;
`ifdef SAP_LOADER_CHECKSUM_EN
               sum_d   = sum_q + i_byte;
`endif
               state_d = S_LO;
            end
         end
         S_LO: begin
            if (accept) begin
               opnd_d  = i_byte;
`ifdef SAP_LOADER_CHECKSUM_EN
               sum_d   = sum_q + i_byte;
`endif
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (last_word) begin
`ifdef SAP_LOADER_CHECKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_DONE;
`endif
            end else begin
               ptr_d   = ptr_q + ADDR_WIDTH'(1);
               state_d = S_HI;
            end
         end
`ifdef SAP_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (accept) begin
               if (i_byte != sum_q) error_d = 1'b1;
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (state_q != S_IDLE && (i_cpu_write || i_cpu_read))
         error_d = 1'b1;
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      hold_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // RAM port mux: CPU passthrough while idle, loader otherwise.
   always_comb begin
      if (state_q == S_IDLE) begin
         o_ram_address = i_cpu_address;
         o_ram_data    = i_cpu_data;
         o_ram_write   = i_cpu_write;
         o_ram_read    = i_cpu_read;
      end else begin
         o_ram_address = ptr_q;
         o_ram_data    = {op_q, opnd_q};
         o_ram_write   = (state_q == S_WRITE);
         o_ram_read    = 1'b0;
      end
   end

   // State and registered outputs; reset aborts any load in flight.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         count_q <= '0;
         op_q    <= '0;
         opnd_q  <= '0;
         busy_q  <= 1'b0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
`ifdef SAP_LOADER_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         busy_q  <= busy_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         error_q <= error_d;
`ifdef SAP_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

endmodule

// File: tb/tb_sap_program_loader.sv
// tb_sap_program_loader: directed and randomized loads checked against
// a transaction-level model of the expected RAM writes and status.
module tb_sap_program_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [4:0]  word_count;
   logic        bvalid;
   logic [7:0]  bdata;
   logic        bready;
   logic [3:0]  cpu_addr;
   logic [15:0] cpu_data;
   logic        cpu_wr;
   logic        cpu_rd;
   logic [3:0]  ram_addr;
   logic [15:0] ram_data;
   logic        ram_wr;
   logic        ram_rd;
   logic        hold;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;
   logic [7:0] prog[$];

   always #5 clk = ~clk;

   sap_program_loader dut (
      .i_clock       (clk),
      .i_reset       (rst_n),
      .i_start       (start),
      .i_word_count  (word_count),
      .i_byte_valid  (bvalid),
      .i_byte        (bdata),
      .o_byte_ready  (bready),
      .i_cpu_address (cpu_addr),
      .i_cpu_data    (cpu_data),
      .i_cpu_write   (cpu_wr),
      .i_cpu_read    (cpu_rd),
      .o_ram_address (ram_addr),
      .o_ram_data    (ram_data),
      .o_ram_write   (ram_wr),
      .o_ram_read    (ram_rd),
      .o_cpu_hold    (hold),
      .o_busy        (busy),
      .o_done        (done),
      .o_error       (err)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic fill_prog(input int nbytes);
      prog.delete();
      for (int i = 0; i < nbytes; i++) prog.push_back(8'($urandom));
   endtask

   task automatic zero_inputs();
      start = 0; word_count = 0; bvalid = 0; bdata = 0;
      cpu_addr = 0; cpu_data = 0; cpu_wr = 0; cpu_rd = 0;
   endtask

   // Random CPU traffic while idle must pass straight to the RAM.
   task automatic idle_check(input int n);
      logic [3:0]  a;
      logic [15:0] d;
      logic        w, r;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         a = 4'($urandom); d = 16'($urandom);
         w = 1'($urandom); r = 1'($urandom);
         cpu_addr = a; cpu_data = d; cpu_wr = w; cpu_rd = r;
         #1;
         chk("idle_addr", ram_addr, a);
         chk("idle_data", ram_data, d);
         chk("idle_wr", ram_wr, w);
         chk("idle_rd", ram_rd, r);
         chk("idle_rdy", bready, 0);
         chk("idle_hold", hold, 0);
      end
      @(negedge clk);
      cpu_addr = 0; cpu_data = 0; cpu_wr = 0; cpu_rd = 0;
   endtask

   // One complete load; expectations come from the byte list alone.
   task automatic run_load(input int wc, input bit gaps, input int poke,
                           input bit bad_chk);
      int m, ndone, done_cyc, gap_ctr, exp_lat;
      logic [7:0]  tx[$];
      logic [15:0] exp_w[$];
      logic [3:0]  got_a[$];
      logic [15:0] got_d[$];
      logic [7:0]  sum;
      bit exp_err, rdy_in_wr, rd_busy, hold_end, err_end;
      m = (wc > 16) ? 16 : wc;
      sum = 0;
      for (int i = 0; i < m; i++) begin
         exp_w.push_back({prog[2*i], prog[2*i+1]});
         tx.push_back(prog[2*i]);
         tx.push_back(prog[2*i+1]);
         sum = sum + prog[2*i] + prog[2*i+1];
      end
      exp_err = (poke >= 0);
      exp_lat = 1 + 3 * m;
`ifdef SAP_LOADER_CHECKSUM_EN
      if (m > 0) begin
         tx.push_back(bad_chk ? sum + 8'd1 : sum);
         if (bad_chk) exp_err = 1;
         exp_lat = exp_lat + 1;
      end
`else
      if (bad_chk) exp_err = exp_err;
`endif
      ndone = 0; done_cyc = -1; gap_ctr = 0;
      rdy_in_wr = 0; rd_busy = 0; hold_end = 1; err_end = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         start = (cyc == 0);
         word_count = 5'(wc);
         cpu_wr = (cyc == poke);
         cpu_addr = 4'($urandom);
         cpu_data = 16'($urandom);
         if (gap_ctr > 0) begin
            bvalid = 0;
            gap_ctr--;
         end else begin
            bvalid = (cyc > 0) && (tx.size() > 0);
         end
         bdata = (tx.size() > 0) ? tx[0] : 8'h00;
         #1;
         if (cyc == 0) chk("start_rdy", bready, 0);
         if (cyc == 1) begin
            chk("c1_err_clr", err, 0);
            chk("c1_hold", hold, 1);
            chk("c1_busy", busy, (m > 0));
         end
         if (cyc >= 1 && ram_wr) begin
            got_a.push_back(ram_addr);
            got_d.push_back(ram_data);
            if (bready) rdy_in_wr = 1;
         end
         if (cyc >= 1 && ram_rd) rd_busy = 1;
         if (bvalid && bready) begin
            void'(tx.pop_front());
            if (gaps) gap_ctr = 3;
         end
         if (done) begin
            ndone++;
            done_cyc = cyc;
         end
         if (ndone > 0 && cyc == done_cyc + 1) begin
            hold_end = hold;
            err_end = err;
            break;
         end
      end
      @(negedge clk);
      zero_inputs();
      chk("done_cnt", ndone, 1);
      chk("wr_cnt", got_a.size(), m);
      for (int i = 0; i < m && i < got_a.size(); i++) begin
         chk("wr_addr", got_a[i], i);
         chk("wr_data", got_d[i], exp_w[i]);
      end
      chk("bytes_left", tx.size(), 0);
      chk("hold_end", hold_end, 0);
      chk("err_end", err_end, exp_err);
      chk("rdy_in_wr", rdy_in_wr, 0);
      chk("rd_busy", rd_busy, 0);
      if (!gaps) chk("latency", done_cyc, exp_lat);
   endtask

   // Reset during LO of word 2 aborts the load and frees the CPU.
   task automatic reset_mid_load();
      int acc;
      bit saw_done;
      fill_prog(8);
      acc = 0;
      @(negedge clk);
      start = 1; word_count = 5'd4;
      @(negedge clk);
      start = 0;
      for (int cyc = 0; cyc < 20 && acc < 3; cyc++) begin
         bvalid = 1; bdata = prog[acc];
         #1;
         if (bready) acc++;
         @(negedge clk);
      end
      chk("mid_acc", acc, 3);
      bvalid = 0;
      rst_n = 0;
      #1;
      chk("rst_rdy", bready, 0);
      chk("rst_wr", ram_wr, 0);
      chk("rst_rd", ram_rd, 0);
      chk("rst_hold", hold, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      cpu_rd = 1; cpu_addr = 4'd3;
      #1;
      chk("rst_cpu_rd", ram_rd, 1);
      chk("rst_cpu_addr", ram_addr, 3);
      @(negedge clk);
      rst_n = 1;
      cpu_rd = 0; cpu_addr = 0;
      saw_done = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         if (done || hold) saw_done = 1;
      end
      chk("rst_no_done", saw_done, 0);
   endtask

   initial begin
      zero_inputs();
      rst_n = 0;
      #12;
      chk("reset_rdy", bready, 0);
      chk("reset_hold", hold, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_wr", ram_wr, 0);
      @(negedge clk);
      rst_n = 1;

      idle_check(4);

      prog.delete();
      prog = '{8'h00, 8'hFF, 8'h01, 8'h7F, 8'h02, 8'h01, 8'h07, 8'h02};
      run_load(4, 0, -1, 0);

      fill_prog(4);
      run_load(2, 1, -1, 0);

      fill_prog(6);
      run_load(3, 0, 1, 0);
      idle_check(2);
      @(negedge clk);
      #1;
      chk("err_sticky", err, 1);

      run_load(0, 0, -1, 0);

      fill_prog(32);
      run_load(20, 0, -1, 0);
      fill_prog(32);
      run_load(16, 0, -1, 0);

`ifdef SAP_LOADER_CHECKSUM_EN
      prog.delete();
      prog = '{8'h01, 8'h02};
      run_load(1, 0, -1, 0);
      run_load(1, 0, -1, 1);
`endif

      for (int k = 0; k < 6; k++) begin
         int wc;
         wc = $urandom_range(0, 20);
         fill_prog(32);
         run_load(wc, 1'($urandom), -1, 0);
      end

      reset_mid_load();

      fill_prog(4);
      run_load(2, 0, -1, 0);
      idle_check(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
